// File: rtl/mips_pkg.sv
// Shared types for the boot-load path into data_memory.
// Loader FSM encoding and byte/word geometry.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    EMIT,
    DONE
  } loader_state_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = WORD_BYTES * BYTE_W;

endpackage

// File: rtl/memory_loader_serializer.sv
// Word-to-byte serialiser for the boot loader.
// Shift register plus byte index with selectable endianness.
module word_serializer
  import mips_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_word,
  input  logic              advance,
  input  logic [WORD_W-1:0] data,
  output logic [BYTE_W-1:0] data_byte,
  output logic              last
);

  logic [WORD_W-1:0] sr;
  logic [1:0]        idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      idx <= '0;
    end else if (load_word) begin
      sr  <= data;
      idx <= '0;
    end else if (advance) begin
      // The outgoing byte always sits at the head of the register.
      if (BIG_ENDIAN)
        sr <= {sr[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      else
        sr <= {{BYTE_W{1'b0}}, sr[WORD_W-1:BYTE_W]};
      idx <= idx + 2'd1;
    end
  end

  assign data_byte = BIG_ENDIAN ? sr[WORD_W-1 -: BYTE_W]
                                : sr[BYTE_W-1:0];
  assign last      = (idx == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/memory_loader.sv
// Boot-load stage: streams host words into data_memory byte by byte
// and gates normal MEM accesses via ready once the image is written.
module memory_loader
  import mips_pkg::*;
#(
  parameter int MEM_BYTES  = 1024,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [8:0]  length,
  input  logic [31:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        load,
  output logic [7:0]  store,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [9:0]  byte_cnt
);

  localparam int         MAX_WORDS = MEM_BYTES / WORD_BYTES;
  localparam logic [8:0] MAX_W     = 9'(MAX_WORDS);
  localparam logic [9:0] BYTE_LAST = 10'(MEM_BYTES - 1);

  loader_state_t state;
  logic [8:0]    target;
  logic [8:0]    word_cnt;
  logic [8:0]    start_target;
  logic [8:0]    word_nxt;
  logic [7:0]    ser_byte;
  logic          ser_last;
  logic          take;

  assign start_target = (length > MAX_W) ? MAX_W : length;
  assign word_nxt     = word_cnt + 9'd1;
  assign take         = (state == ACCEPT) && in_valid && in_ready;

  word_serializer #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_word(take),
    .advance  (state == EMIT),
    .data     (in_word),
    .data_byte(ser_byte),
    .last     (ser_last)
  );

  // Byte lane is quiet whenever no write strobe is presented.
  assign store = load ? ser_byte : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      target   <= '0;
      word_cnt <= '0;
      in_ready <= 1'b0;
      load     <= 1'b0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            target   <= start_target;
            word_cnt <= '0;
            byte_cnt <= '0;
            if (start_target == '0) begin
              state <= DONE;
              ready <= 1'b1;
              done  <= 1'b1;
            end else begin
              state    <= ACCEPT;
              ready    <= 1'b0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            state    <= EMIT;
            in_ready <= 1'b0;
            load     <= 1'b1;
          end
        end
        EMIT: begin
          byte_cnt <= (byte_cnt == BYTE_LAST) ? '0
                                              : byte_cnt + 10'd1;
          if (ser_last) begin
            load     <= 1'b0;
            word_cnt <= word_nxt;
            if (word_nxt == target) begin
              state <= DONE;
              busy  <= 1'b0;
              ready <= 1'b1;
              done  <= 1'b1;
            end else begin
              state    <= ACCEPT;
              in_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_loader.sv
// Directed bench for memory_loader: table of single-word loads plus
// sequences for back-pressure, zero length, saturation, reset, restart.
module tb_memory_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  length;
  logic [31:0] in_word;
  logic        in_valid;

  logic       in_ready_be, load_be, ready_be, busy_be, done_be;
  logic [7:0] store_be;
  logic [9:0] cnt_be;
  logic       in_ready_le, load_le, ready_le, busy_le, done_le;
  logic [7:0] store_le;
  logic [9:0] cnt_le;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  qbe[$];
  logic [7:0]  qle[$];
  logic [31:0] words[300];

  typedef struct {
    logic [31:0] word;
    logic [31:0] exp_be;
    logic [31:0] exp_le;
  } vec_t;
  vec_t tbl[3];

  always #5 clk = ~clk;

  memory_loader #(.MEM_BYTES(1024), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst_n(rst_n), .start(start), .length(length),
    .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready_be),
    .load(load_be), .store(store_be), .ready(ready_be),
    .busy(busy_be), .done(done_be), .byte_cnt(cnt_be)
  );

  memory_loader #(.MEM_BYTES(1024), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst_n(rst_n), .start(start), .length(length),
    .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready_le),
    .load(load_le), .store(store_le), .ready(ready_le),
    .busy(busy_le), .done(done_le), .byte_cnt(cnt_le)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Run one load; stops in the cycle where done is seen.
  task automatic drive(input int len, input int nwords, input int gap,
                       input int poke, output int loads,
                       output int accepts, output int bad);
    int  idx;
    int  gcnt;
    bit  seen;
    loads = 0; accepts = 0; bad = 0;
    idx = 0; gcnt = 0; seen = 0;
    qbe.delete();
    qle.delete();
    length = 9'(len);
    start  = 1'b1;
    tick;
    start  = 1'b0;
    for (int c = 0; c < 5000 && !seen; c++) begin
      if (load_be) begin
        loads++;
        qbe.push_back(store_be);
        qle.push_back(store_le);
      end
      if (load_be && (ready_be || in_ready_be)) bad++;
      if (load_le != load_be) bad++;
      if (ready_be && !done_be) bad++;
      if (done_be) seen = 1;
      start = (poke != 0 && load_be && loads == poke);
      if (!seen && idx < nwords && gcnt == 0) begin
        in_valid = 1'b1;
        in_word  = words[idx];
      end else begin
        in_valid = 1'b0;
        if (gcnt > 0) gcnt--;
      end
      if (in_valid && in_ready_be) begin
        accepts++;
        idx++;
        gcnt = gap;
      end
      if (!seen) tick;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int loads, accepts, bad;
    logic [31:0] got;

    tbl[0] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hEFBEADDE};
    tbl[1] = '{32'h11223344, 32'h11223344, 32'h44332211};
    tbl[2] = '{32'h00FF8001, 32'h00FF8001, 32'h0180FF00};

    rst_n = 1'b0; start = 1'b0; length = '0;
    in_word = '0; in_valid = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready_be), 0);
    check("rst_load", 32'(load_be), 0);
    check("rst_store", 32'(store_be), 0);
    check("rst_ready", 32'(ready_be), 0);
    check("rst_busy", 32'({busy_be, busy_le}), 0);
    check("rst_done", 32'(done_be), 0);
    check("rst_byte_cnt", 32'(cnt_be), 0);
    rst_n = 1'b1;
    tick;
    tick;

    for (int v = 0; v < 3; v++) begin
      words[0] = tbl[v].word;
      drive(1, 1, 0, 0, loads, accepts, bad);
      check("tbl_loads", 32'(loads), 4);
      got = {qbe[0], qbe[1], qbe[2], qbe[3]};
      check("tbl_be_bytes", got, tbl[v].exp_be);
      got = {qle[0], qle[1], qle[2], qle[3]};
      check("tbl_le_bytes", got, tbl[v].exp_le);
      check("tbl_byte_cnt", 32'(cnt_be), 4);
      check("tbl_done_ready", 32'({done_be, ready_be, busy_be}), 32'b110);
      check("tbl_bad", 32'(bad), 0);
      tick;
      check("tbl_done_pulse", 32'({done_be, ready_be}), 32'b01);
    end

    words[0] = 32'h01020304;
    words[1] = 32'h05060708;
    words[2] = 32'h090A0B0C;
    drive(3, 3, 7, 0, loads, accepts, bad);
    check("bp_loads", 32'(loads), 12);
    check("bp_accepts", 32'(accepts), 3);
    for (int i = 0; i < 12 && i < qbe.size(); i++)
      check("bp_byte", 32'(qbe[i]), 32'(i + 1));
    check("bp_bad", 32'(bad), 0);
    check("bp_byte_cnt", 32'(cnt_be), 12);

    drive(0, 0, 0, 0, loads, accepts, bad);
    check("zero_loads", 32'(loads), 0);
    check("zero_done_ready", 32'({done_be, ready_be}), 32'b11);
    tick;
    check("zero_pulse", 32'({done_be, ready_be, load_be}), 32'b010);

    for (int i = 0; i < 300; i++) words[i] = 32'(i * 32'h01010101);
    drive(300, 300, 0, 0, loads, accepts, bad);
    check("sat_accepts", 32'(accepts), 256);
    check("sat_loads", 32'(loads), 1024);
    check("sat_byte_cnt", 32'(cnt_be), 0);
    check("sat_ready", 32'(ready_be), 1);
    check("sat_bad", 32'(bad), 0);
    tick;
    check("sat_in_ready", 32'(in_ready_be), 0);

    words[0] = 32'h44556677;
    drive(1, 1, 0, 2, loads, accepts, bad);
    check("ign_loads", 32'(loads), 4);
    check("ign_accepts", 32'(accepts), 1);
    words[0] = 32'h11223344;
    drive(1, 1, 0, 2, loads, accepts, bad);
    got = {qle[0], qle[1], qle[2], qle[3]};
    check("ign_le_bytes", got, 32'h44332211);
    check("ign_loads2", 32'(loads), 4);
    check("ign_byte_cnt", 32'(cnt_le), 4);
    length = 9'd1;
    start  = 1'b1;
    tick;
    start  = 1'b0;
    check("restart_ready", 32'({ready_le, busy_le, in_ready_le}), 32'b011);

    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick;
    length   = 9'd2;
    start    = 1'b1;
    tick;
    start    = 1'b0;
    in_valid = 1'b1;
    in_word  = 32'hCAFEF00D;
    tick;
    in_valid = 1'b0;
    check("rm_byte0", 32'(store_be), 32'hCA);
    tick;
    check("rm_byte1", 32'({load_be, store_be}), 32'h1FE);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_async", 32'({load_be, ready_be, busy_be, in_ready_be}), 0);
    check("rm_byte_cnt", 32'(cnt_be), 0);
    #2;
    rst_n = 1'b1;
    tick;
    check("rm_idle", 32'({load_be, ready_be, busy_be, in_ready_be}), 0);
    words[0] = 32'hA1B2C3D4;
    drive(1, 1, 0, 0, loads, accepts, bad);
    got = {qbe[0], qbe[1], qbe[2], qbe[3]};
    check("rm_reload_bytes", got, 32'hA1B2C3D4);
    check("rm_reload_cnt", 32'(cnt_be), 4);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
